bcd_mmss_timer: RTL and testbench
=================================

# bcd_mmss_timer

Parametrised BCD minutes:seconds timer, successor to the fixed 0–29:59 up-counter in the display path. Drives four BCD digits straight into the seven-segment scan logic from the 1 Hz time base. Adds a synchronous reset, run/hold, clear, preset load, count-down mode with completion flag, and a configurable minute limit with wrap-or-saturate selection.

## Interface
- `MIN_LIMIT`, default 29: highest minutes value displayed (1..99); the count range is 00:00..MIN_LIMIT:59.
- `WRAP`, default 1: up-mode behaviour at the limit. 1 wraps to 00:00; 0 holds at the limit and sets `done`.
- `clk_1hz` input, 1 bit: 1 Hz clock. One rising edge is one second.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: 1 counts on each edge; 0 holds.
- `up_dn` input, 1 bit: 1 counts up; 0 counts down.
- `clr` input, 1 bit: synchronous clear to 00:00.
- `load` input, 1 bit: synchronous preset from the `ld*` digits.
- `ld0`, `ld1`, `ld2`, `ld3` input, 4 bits each: preset digits for seconds ones, seconds tens, minutes ones and minutes tens.
- `time0`, `time1`, `time2`, `time3` output, 4 bits each: BCD digits for seconds ones (0–9), seconds tens (0–5), minutes ones (0–9) and minutes tens (0–9, bounded by `MIN_LIMIT`).
- `done` output, 1 bit: level flag. Set on count-down reaching 00:00, or on saturating at the limit when `WRAP`=0.
- `wrap` output, 1 bit: one-cycle pulse on the edge where up-mode wraps from the limit to 00:00.

## Operation
- All state is registered on the `clk_1hz` rising edge.
- Priority per edge: `rst` > `clr` > `load` > (`en` and not `done`) count > hold.
- `rst` sets all `time*` = 0, `done` = 0, `wrap` = 0.
- `clr` has the same effect as `rst`.
- `load` behaviour:
  - Each digit is clamped independently: ones digits to 9, `ld1` to 5.
  - The minutes value (`ld3`·10 + `ld2`) is then clamped to `MIN_LIMIT`.
  - `done` is cleared and `wrap` is 0.
- Up count: a digit cascade in which seconds ones wraps 9→0 and carries into seconds tens; seconds tens wraps 5→0 and carries into minutes.
- Up count at the limit (minutes = `MIN_LIMIT`, seconds = 59):
  - With `WRAP`=1: next value is 00:00 and `wrap` pulses.
  - With `WRAP`=0: the count holds and `done` is set.
- Down count:
  - Seconds ones borrows 0→9; seconds tens borrows 0→5; the minutes digits borrow likewise.
  - On the edge that produces 00:00, `done` is set.
  - While `done` = 1 the counter holds until `clr`, `load` or `rst`.
- Changing `up_dn` while `done` = 1 does not release the hold; only `clr`, `load` or `rst` clears `done`.
- Down count from 00:00 with `done` = 0 (after `clr`): the count holds at 00:00 and `done` is set on that edge; there is no underflow.
- Minutes arithmetic is done on the two BCD digits. Minutes tens wraps or stops per `MIN_LIMIT`, not at 9.

## Timing
- Latency is one edge. An input sampled at edge n is visible on the outputs after edge n.
- `wrap` is high for exactly the one cycle following the wrap edge, then returns to 0.
- `done` rises in the same cycle the terminal value appears.
- Control inputs must be synchronous to `clk_1hz`; the block adds no synchronisers.
- A `load` or `clr` that arrives on the same edge as a carry wins; the carry is discarded.

## Structure
- Shared package `timer_pkg` holds:
  - the BCD digit type (4-bit);
  - the digit moduli constants (10 and 6);
  - a BCD clamp function, reused by the load path.
- Natural sub-module `bcd_digit`:
  - parameter `MOD`;
  - inputs: `inc`, `dec`, `clr`, `ld`, `ld_val`;
  - outputs: digit value, `carry`, `borrow`.
- The top instantiates four `bcd_digit` cells. Its own logic covers the limit compare, `done`/`wrap` and clamping.

## Test plan
- Reset and up count:
  - Stimulus: `rst` 1 cycle, then `en`=1, `up_dn`=1 for 61 edges.
  - Response: 01:01; `done`=0; `wrap`=0.
- Wrap (`MIN_LIMIT`=29, `WRAP`=1):
  - Stimulus: load 29:58, run 2 edges.
  - Response: 29:59, then 00:00 with `wrap`=1 for one cycle.
- Saturate (`WRAP`=0):
  - Stimulus: load 29:59, run 3 edges.
  - Response: holds 29:59 with `done`=1.
- Count-down:
  - Stimulus: load 01:00, `up_dn`=0, run 60 edges.
  - Response: 00:59 after edge 1; 00:00 with `done`=1 after edge 60; held at 00:00 on further edges.
- Clamp:
  - Stimulus: load digits 3,7,F,9 (`ld3`..`ld0`) with `MIN_LIMIT`=29.
  - Response: 29:59.
- Priority:
  - Stimulus: assert `clr` and `load` together during a carry edge (from 09:59).
  - Response: 00:00; `done`=0; `wrap`=0.

Source files
------------

// File: rtl/bcd_mmss_timer_pkg.sv
// Shared types and helpers for the BCD minutes:seconds timer.
// Digit type, digit moduli and the clamp used by the preset path.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned MOD_ONES = 10;
  localparam int unsigned MOD_TENS = 6;

  function automatic bcd_t bcd_clamp(input bcd_t val, input bcd_t max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/bcd_mmss_timer_if.sv
// Control/preset/display bundle between the timer and its user.
// The master drives controls and presets; the slave (timer) drives digits and flags.
interface bcd_mmss_timer_if;
  import timer_pkg::*;

  logic en;
  logic up_dn;
  logic clr;
  logic load;
  bcd_t ld0, ld1, ld2, ld3;
  bcd_t time0, time1, time2, time3;
  logic done;
  logic wrap;

  modport master (
    output en, up_dn, clr, load, ld0, ld1, ld2, ld3,
    input  time0, time1, time2, time3, done, wrap
  );

  modport slave (
    input  en, up_dn, clr, load, ld0, ld1, ld2, ld3,
    output time0, time1, time2, time3, done, wrap
  );

endinterface

// File: rtl/bcd_mmss_timer_digit.sv
// One BCD digit cell of modulus MOD with clear, preset, increment and decrement.
// carry/borrow flag the step that wraps this digit, feeding the next cell.
module bcd_digit
  import timer_pkg::*;
#(
  parameter int unsigned MOD = MOD_ONES
) (
  input  logic clk_1hz,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  output bcd_t digit,
  output logic carry,
  output logic borrow
);

  localparam bcd_t TOP = bcd_t'(MOD - 1);

  bcd_t digit_q, digit_d;

  always_comb begin
    // NOTE: default assignment first so every path drives digit_d and no latch is inferred.
    digit_d = digit_q;
    if (clr)      digit_d = '0;
    else if (ld)  digit_d = ld_val;
    else if (inc) digit_d = (digit_q == TOP) ? '0 : digit_q + 4'd1;
    else if (dec) digit_d = (digit_q == '0) ? TOP : digit_q - 4'd1;
  end

  always_ff @(posedge clk_1hz) begin
    // NOTE: non-blocking so every register samples pre-edge values of the others.
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit  = digit_q;
  assign carry  = inc && (digit_q == TOP);
  assign borrow = dec && (digit_q == '0);

endmodule

// File: rtl/bcd_mmss_timer.sv
// BCD mm:ss timer driven by a 1 Hz clock: up/down count, preset, clear,
// configurable minute limit with wrap or saturate, done level and wrap pulse.
module bcd_mmss_timer
  import timer_pkg::*;
#(
  parameter int unsigned MIN_LIMIT = 29,
  parameter bit          WRAP      = 1'b1
) (
  input logic              clk_1hz,
  input logic              rst,
  bcd_mmss_timer_if.slave  bus
);

  localparam bcd_t LIM_TENS = bcd_t'(MIN_LIMIT / 10);
  localparam bcd_t LIM_ONES = bcd_t'(MIN_LIMIT % 10);
  localparam bcd_t MAX_ONES = bcd_t'(MOD_ONES - 1);
  localparam bcd_t MAX_TENS = bcd_t'(MOD_TENS - 1);

  bcd_t q0, q1, q2, q3;
  logic c0, c1, c2, c3;
  logic b0, b1, b2, b3;
  logic unused_msd;

  bcd_t ld_c0, ld_c1, ld_c2, ld_c3;
  logic [6:0] ld_min;

  logic count, at_limit, at_zero, at_one;
  logic up_step, dn_step, wrap_now, sat_now, zero_now, dig_clr;
  logic done_q, done_d, wrap_q, wrap_d;

  // Digits clamp individually first; the combined minutes then clamp to the limit.
  always_comb begin
    ld_c0  = bcd_clamp(bus.ld0, MAX_ONES);
    ld_c1  = bcd_clamp(bus.ld1, MAX_TENS);
    ld_c2  = bcd_clamp(bus.ld2, MAX_ONES);
    ld_c3  = bcd_clamp(bus.ld3, MAX_ONES);
    ld_min = 7'(ld_c3) * 7'd10 + 7'(ld_c2);
    if (ld_min > 7'(MIN_LIMIT)) begin
      ld_c3 = LIM_TENS;
      ld_c2 = LIM_ONES;
    end
  end

  assign count    = bus.en && !done_q && !bus.clr && !bus.load;
  assign at_limit = (q3 == LIM_TENS) && (q2 == LIM_ONES) && (q1 == MAX_TENS) && (q0 == MAX_ONES);
  assign at_zero  = ({q3, q2, q1, q0} == 16'h0000);
  assign at_one   = ({q3, q2, q1, q0} == 16'h0001);

  assign up_step  = count &&  bus.up_dn && !at_limit;
  assign dn_step  = count && !bus.up_dn && !at_zero;
  assign wrap_now = count &&  bus.up_dn &&  at_limit &&  WRAP;
  assign sat_now  = count &&  bus.up_dn &&  at_limit && !WRAP;
  assign zero_now = count && !bus.up_dn && (at_zero || at_one);
  assign dig_clr  = bus.clr || wrap_now;

  bcd_digit #(.MOD(MOD_ONES)) u_sec_ones (
    .clk_1hz(clk_1hz), .rst(rst), .inc(up_step), .dec(dn_step), .clr(dig_clr),
    .ld(bus.load), .ld_val(ld_c0), .digit(q0), .carry(c0), .borrow(b0)
  );

  bcd_digit #(.MOD(MOD_TENS)) u_sec_tens (
    .clk_1hz(clk_1hz), .rst(rst), .inc(c0), .dec(b0), .clr(dig_clr),
    .ld(bus.load), .ld_val(ld_c1), .digit(q1), .carry(c1), .borrow(b1)
  );

  bcd_digit #(.MOD(MOD_ONES)) u_min_ones (
    .clk_1hz(clk_1hz), .rst(rst), .inc(c1), .dec(b1), .clr(dig_clr),
    .ld(bus.load), .ld_val(ld_c2), .digit(q2), .carry(c2), .borrow(b2)
  );

  bcd_digit #(.MOD(MOD_ONES)) u_min_tens (
    .clk_1hz(clk_1hz), .rst(rst), .inc(c2), .dec(b2), .clr(dig_clr),
    .ld(bus.load), .ld_val(ld_c3), .digit(q3), .carry(c3), .borrow(b3)
  );

  // The limit compare stops the count before minutes tens could ever wrap.
  assign unused_msd = c3 | b3;

  always_comb begin
    done_d = done_q;
    if (bus.clr || bus.load)     done_d = 1'b0;
    else if (sat_now || zero_now) done_d = 1'b1;
    wrap_d = wrap_now;
  end

  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.time0 = q0;
  assign bus.time1 = q1;
  assign bus.time2 = q2;
  assign bus.time3 = q3;
  assign bus.done  = done_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_mmss_timer.sv
// Self-checking bench: two timers (wrap and saturate) share one stimulus stream
// and are compared against a total-seconds reference model and directed values.
module tb_bcd_mmss_timer;
  import timer_pkg::*;

  localparam int LIMIT = 29;
  localparam int LIM_T = LIMIT * 60 + 59;

  logic clk_1hz = 1'b0;
  logic s_rst, s_en, s_up, s_clr, s_load;
  logic [3:0] s_ld [4];

  int n_tests = 0;
  int n_fail  = 0;

  int t_w = 0, t_s = 0;
  bit d_w = 0, d_s = 0, w_w = 0, w_s = 0;

  always #5 clk_1hz = ~clk_1hz;

  bcd_mmss_timer_if if_w ();
  bcd_mmss_timer_if if_s ();

  assign if_w.en = s_en;     assign if_s.en = s_en;
  assign if_w.up_dn = s_up;  assign if_s.up_dn = s_up;
  assign if_w.clr = s_clr;   assign if_s.clr = s_clr;
  assign if_w.load = s_load; assign if_s.load = s_load;
  assign if_w.ld0 = s_ld[0]; assign if_s.ld0 = s_ld[0];
  assign if_w.ld1 = s_ld[1]; assign if_s.ld1 = s_ld[1];
  assign if_w.ld2 = s_ld[2]; assign if_s.ld2 = s_ld[2];
  assign if_w.ld3 = s_ld[3]; assign if_s.ld3 = s_ld[3];

  bcd_mmss_timer #(.MIN_LIMIT(LIMIT), .WRAP(1'b1)) dut_w (
    .clk_1hz(clk_1hz), .rst(s_rst), .bus(if_w.slave)
  );

  bcd_mmss_timer #(.MIN_LIMIT(LIMIT), .WRAP(1'b0)) dut_s (
    .clk_1hz(clk_1hz), .rst(s_rst), .bus(if_s.slave)
  );

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference: the time is a plain count of seconds 0..LIM_T.
  function automatic void model_step(input bit wrapmode, inout int t, inout bit d, inout bit w);
    int m;
    if (s_rst || s_clr) begin
      t = 0; d = 0; w = 0;
    end else if (s_load) begin
      m = clampi(int'(s_ld[3]), 9) * 10 + clampi(int'(s_ld[2]), 9);
      m = clampi(m, LIMIT);
      t = m * 60 + clampi(int'(s_ld[1]), 5) * 10 + clampi(int'(s_ld[0]), 9);
      d = 0; w = 0;
    end else begin
      w = 0;
      if (s_en && !d) begin
        if (s_up) begin
          if (t == LIM_T) begin
            if (wrapmode) begin t = 0; w = 1; end
            else d = 1;
          end else t++;
        end else begin
          if (t <= 1) begin t = 0; d = 1; end
          else t--;
        end
      end
    end
  endfunction

  function automatic logic [23:0] pack(input int t, input bit d, input bit w);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 3'b000, d, 3'b000, w};
  endfunction

  function automatic logic [23:0] obs_w();
    return {if_w.time3, if_w.time2, if_w.time1, if_w.time0, 3'b000, if_w.done, 3'b000, if_w.wrap};
  endfunction

  function automatic logic [23:0] obs_s();
    return {if_s.time3, if_s.time2, if_s.time1, if_s.time0, 3'b000, if_s.done, 3'b000, if_s.wrap};
  endfunction

  task automatic tick();
    model_step(1'b1, t_w, d_w, w_w);
    model_step(1'b0, t_s, d_s, w_s);
    @(posedge clk_1hz);
    #1;
  endtask

  task automatic idle();
    s_rst = 0; s_en = 0; s_up = 1; s_clr = 0; s_load = 0;
  endtask

  task automatic set_ld(input logic [3:0] m10, input logic [3:0] m1, input logic [3:0] s10, input logic [3:0] s1);
    s_ld[3] = m10; s_ld[2] = m1; s_ld[1] = s10; s_ld[0] = s1;
  endtask

  task automatic test_reset();
    logic [23:0] got;
    idle(); set_ld(0, 0, 0, 0);
    s_rst = 1; tick(); s_rst = 0;
    got = obs_w(); n_tests++;
    if (got !== 24'h000000) begin n_fail++; $display("FAIL reset_w: got %h want %h", got, 24'h000000); end
    got = obs_s(); n_tests++;
    if (got !== 24'h000000) begin n_fail++; $display("FAIL reset_s: got %h want %h", got, 24'h000000); end
  endtask

  task automatic test_up_count();
    logic [23:0] got;
    s_en = 1; s_up = 1;
    repeat (61) tick();
    got = obs_w(); n_tests++;
    if (got !== 24'h010100) begin n_fail++; $display("FAIL up_count_w: got %h want %h", got, 24'h010100); end
    got = obs_s(); n_tests++;
    if (got !== 24'h010100) begin n_fail++; $display("FAIL up_count_s: got %h want %h", got, 24'h010100); end
    got = obs_w(); n_tests++;
    if (got !== pack(t_w, d_w, w_w)) begin n_fail++; $display("FAIL up_count_model: got %h want %h", got, pack(t_w, d_w, w_w)); end
  endtask

  task automatic test_wrap();
    logic [23:0] got;
    idle(); set_ld(2, 9, 5, 8); s_load = 1; tick(); s_load = 0;
    s_en = 1; s_up = 1; tick();
    got = obs_w(); n_tests++;
    if (got !== 24'h295900) begin n_fail++; $display("FAIL wrap_pre: got %h want %h", got, 24'h295900); end
    tick();
    got = obs_w(); n_tests++;
    if (got !== 24'h000001) begin n_fail++; $display("FAIL wrap_edge: got %h want %h", got, 24'h000001); end
    got = obs_s(); n_tests++;
    if (got !== 24'h295910) begin n_fail++; $display("FAIL sat_edge: got %h want %h", got, 24'h295910); end
    tick();
    got = obs_w(); n_tests++;
    if (got !== 24'h000100) begin n_fail++; $display("FAIL wrap_pulse_end: got %h want %h", got, 24'h000100); end
  endtask

  task automatic test_saturate();
    logic [23:0] got;
    set_ld(2, 9, 5, 9); s_load = 1; s_en = 1; s_up = 1; tick(); s_load = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = obs_s(); n_tests++;
      if (got !== 24'h295910) begin n_fail++; $display("FAIL saturate_%0d: got %h want %h", i, got, 24'h295910); end
    end
    got = obs_w(); n_tests++;
    if (got !== 24'h000200) begin n_fail++; $display("FAIL wrap_after3: got %h want %h", got, 24'h000200); end
    s_up = 0; tick();
    got = obs_s(); n_tests++;
    if (got !== 24'h295910) begin n_fail++; $display("FAIL done_hold_dir: got %h want %h", got, 24'h295910); end
  endtask

  task automatic test_count_down();
    logic [23:0] got;
    set_ld(0, 1, 0, 0); s_load = 1; s_en = 1; s_up = 0; tick(); s_load = 0;
    tick();
    got = obs_w(); n_tests++;
    if (got !== 24'h005900) begin n_fail++; $display("FAIL down_first: got %h want %h", got, 24'h005900); end
    repeat (59) tick();
    got = obs_w(); n_tests++;
    if (got !== 24'h000010) begin n_fail++; $display("FAIL down_done_w: got %h want %h", got, 24'h000010); end
    got = obs_s(); n_tests++;
    if (got !== 24'h000010) begin n_fail++; $display("FAIL down_done_s: got %h want %h", got, 24'h000010); end
    repeat (2) tick();
    got = obs_w(); n_tests++;
    if (got !== 24'h000010) begin n_fail++; $display("FAIL down_hold: got %h want %h", got, 24'h000010); end
  endtask

  task automatic test_clamp();
    logic [23:0] got;
    idle(); set_ld(4'h3, 4'h7, 4'hF, 4'h9); s_load = 1; tick(); s_load = 0;
    got = obs_w(); n_tests++;
    if (got !== 24'h295900) begin n_fail++; $display("FAIL clamp: got %h want %h", got, 24'h295900); end
    s_clr = 1; tick(); s_clr = 0;
    s_en = 1; s_up = 0; tick();
    got = obs_s(); n_tests++;
    if (got !== 24'h000010) begin n_fail++; $display("FAIL down_from_zero: got %h want %h", got, 24'h000010); end
  endtask

  task automatic test_priority();
    logic [23:0] got;
    idle(); set_ld(0, 9, 5, 9); s_load = 1; tick();
    s_en = 1; s_up = 1; s_clr = 1; set_ld(1, 2, 3, 4); tick();
    got = obs_w(); n_tests++;
    if (got !== 24'h000000) begin n_fail++; $display("FAIL clr_over_carry: got %h want %h", got, 24'h000000); end
    idle(); set_ld(0, 9, 5, 9); s_load = 1; tick();
    s_en = 1; set_ld(1, 2, 3, 4); tick();
    got = obs_w(); n_tests++;
    if (got !== 24'h123400) begin n_fail++; $display("FAIL load_over_carry: got %h want %h", got, 24'h123400); end
    idle(); tick();
    got = obs_s(); n_tests++;
    if (got !== 24'h123400) begin n_fail++; $display("FAIL hold_en0: got %h want %h", got, 24'h123400); end
  endtask

  task automatic test_random();
    logic [23:0] got;
    int shown = 0;
    idle();
    for (int i = 0; i < 600; i++) begin
      s_rst  = ($urandom % 60) == 0;
      s_clr  = ($urandom % 45) == 0;
      s_load = ($urandom % 12) == 0;
      s_en   = ($urandom % 5) != 0;
      if (($urandom % 40) == 0) s_up = ~s_up;
      set_ld(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      tick();
      got = obs_w(); n_tests++;
      if (got !== pack(t_w, d_w, w_w)) begin
        n_fail++;
        if (shown < 10) $display("FAIL random_w[%0d]: got %h want %h", i, got, pack(t_w, d_w, w_w));
        shown++;
      end
      got = obs_s(); n_tests++;
      if (got !== pack(t_s, d_s, w_s)) begin
        n_fail++;
        if (shown < 10) $display("FAIL random_s[%0d]: got %h want %h", i, got, pack(t_s, d_s, w_s));
        shown++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_wrap();
    test_saturate();
    test_count_down();
    test_clamp();
    test_priority();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
